// File: rtl/bus_hold_ctl.sv
// ---------------------------------------------------------------------------
// bus_hold_ctl
//   Produces the three clock-hold requests for the M/T-cycle sequencer.
//   It inserts the automatic I/O wait states in T2, stretches T2 while the
//   external nWAIT pin is low, and runs the BUSRQ/BUSACK bus-release handshake.
//
// Parameters
//   IO_WAITS     automatic wait states added in T2 of an I/O cycle (0..7)
//   SYNC_INPUTS  1 = double-flop nWAIT/nBUSRQ, 0 = use the pins directly
//
// Ports
//   clk, nreset     clock and asynchronous active-low reset
//   T1, T2          sequencer T-state flags (one-hot)
//   last_t          current T-state is the last one of this M-cycle
//   io_cycle        current M-cycle is an I/O read/write
//   bus_cycle       current M-cycle drives memory or I/O (WAIT applies)
//   nWAIT, nBUSRQ   external wait / bus request pins, active low
//   hold_clk_iorq   freeze sequencer for an automatic I/O wait state
//   hold_clk_wait   freeze sequencer for external WAIT
//   hold_clk_busrq  freeze sequencer while the bus is released
//   nBUSACK         bus acknowledge pin, active low
//   bus_oe          1 = CPU may drive address/data/control
//   in_tw           current clock is a wait state
// ---------------------------------------------------------------------------
module bus_hold_ctl #(
    parameter int IO_WAITS    = 1,
    parameter int SYNC_INPUTS = 0
) (
    input  logic clk,
    input  logic nreset,
    input  logic T1,
    input  logic T2,
    input  logic last_t,
    input  logic io_cycle,
    input  logic bus_cycle,
    input  logic nWAIT,
    input  logic nBUSRQ,
    output logic hold_clk_iorq,
    output logic hold_clk_wait,
    output logic hold_clk_busrq,
    output logic nBUSACK,
    output logic bus_oe,
    output logic in_tw
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_REL     = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    localparam logic [2:0] IO_WAITS_C = 3'(IO_WAITS);

    state_t     state_q, state_d;
    logic [2:0] io_cnt_q, io_cnt_d;
    logic       nwait_s;
    logic       nbusrq_s;
    logic       run;
    logic       iorq_pending;

    // T1 belongs to the sequencer flag bundle but nothing here depends on it.
    logic       unused_t1;
    assign unused_t1 = T1;

    // Optional two-stage synchronisers; flops reset to the inactive level so
    // a release from reset never sees a phantom request.
    if (SYNC_INPUTS != 0) begin : g_sync
        logic [1:0] wait_sync_q;
        logic [1:0] busrq_sync_q;

        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                wait_sync_q  <= 2'b11;
                busrq_sync_q <= 2'b11;
            end else begin
                wait_sync_q  <= {wait_sync_q[0], nWAIT};
                busrq_sync_q <= {busrq_sync_q[0], nBUSRQ};
            end
        end

        assign nwait_s  = wait_sync_q[1];
        assign nbusrq_s = busrq_sync_q[1];
    end else begin : g_nosync
        assign nwait_s  = nWAIT;
        assign nbusrq_s = nBUSRQ;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= ST_RUN;
            io_cnt_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            io_cnt_q <= io_cnt_d;
        end
    end

    // Holds are combinational from registered state so they act in the very
    // T2 clock that needs them. The I/O count wins over WAIT, so external
    // WAIT is only honoured once all automatic waits have been served.
    always_comb begin
        run            = (state_q == ST_RUN);
        iorq_pending   = (io_cnt_q < IO_WAITS_C);
        hold_clk_iorq  = run & T2 & io_cycle & iorq_pending;
        hold_clk_wait  = run & T2 & bus_cycle & ~hold_clk_iorq & ~nwait_s;
        in_tw          = hold_clk_iorq | hold_clk_wait;
    end

    // The I/O wait counter only lives inside T2 of RUN; it saturates at
    // IO_WAITS so the iorq hold drops after exactly that many clocks.
    always_comb begin
        io_cnt_d = io_cnt_q;
        if (!run || !T2) begin
            io_cnt_d = 3'd0;
        end else if (io_cycle && iorq_pending) begin
            io_cnt_d = io_cnt_q + 3'd1;
        end
    end

    // Bus request is only sampled at the end of an M-cycle that is not being
    // stretched; the sequencer steps into T1 on the same edge we enter REL
    // and stays frozen there through REL and the one RECOVER turnaround clock.
    always_comb begin
        state_d        = state_q;
        hold_clk_busrq = 1'b0;
        nBUSACK        = 1'b1;
        bus_oe         = 1'b1;
        case (state_q)
            ST_RUN: begin
                if (last_t && !in_tw && !nbusrq_s) begin
                    state_d = ST_REL;
                end
            end
            ST_REL: begin
                hold_clk_busrq = 1'b1;
                nBUSACK        = 1'b0;
                bus_oe         = 1'b0;
                if (nbusrq_s) begin
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                hold_clk_busrq = 1'b1;
                state_d        = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_hold_ctl.sv
// ---------------------------------------------------------------------------
// tb_bus_hold_ctl
//   Directed bench for bus_hold_ctl. Two instances share all inputs:
//   dut  (IO_WAITS=1, SYNC_INPUTS=0) and dut3 (IO_WAITS=3, SYNC_INPUTS=1).
//   Outputs are packed as {iorq, wait, busrq, nBUSACK, bus_oe, in_tw}.
//   Inputs change 1 time unit after a rising edge; outputs are sampled on
//   the falling edge.
// ---------------------------------------------------------------------------
module tb_bus_hold_ctl;

    logic clk = 1'b0;
    logic nreset;
    logic T1, T2, last_t, io_cycle, bus_cycle, nWAIT, nBUSRQ;

    logic iorq_a, wait_a, busrq_a, nbusack_a, oe_a, tw_a;
    logic iorq_b, wait_b, busrq_b, nbusack_b, oe_b, tw_b;

    logic [5:0] obs, obs3;
    assign obs  = {iorq_a, wait_a, busrq_a, nbusack_a, oe_a, tw_a};
    assign obs3 = {iorq_b, wait_b, busrq_b, nbusack_b, oe_b, tw_b};

    localparam logic [5:0] IDLE = 6'b000110;
    localparam logic [5:0] IORQ = 6'b100111;
    localparam logic [5:0] WAIT = 6'b010111;
    localparam logic [5:0] REL  = 6'b001000;
    localparam logic [5:0] RECV = 6'b001110;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_hold_ctl #(.IO_WAITS(1), .SYNC_INPUTS(0)) dut (
        .clk(clk), .nreset(nreset), .T1(T1), .T2(T2), .last_t(last_t),
        .io_cycle(io_cycle), .bus_cycle(bus_cycle), .nWAIT(nWAIT), .nBUSRQ(nBUSRQ),
        .hold_clk_iorq(iorq_a), .hold_clk_wait(wait_a), .hold_clk_busrq(busrq_a),
        .nBUSACK(nbusack_a), .bus_oe(oe_a), .in_tw(tw_a)
    );

    bus_hold_ctl #(.IO_WAITS(3), .SYNC_INPUTS(1)) dut3 (
        .clk(clk), .nreset(nreset), .T1(T1), .T2(T2), .last_t(last_t),
        .io_cycle(io_cycle), .bus_cycle(bus_cycle), .nWAIT(nWAIT), .nBUSRQ(nBUSRQ),
        .hold_clk_iorq(iorq_b), .hold_clk_wait(wait_b), .hold_clk_busrq(busrq_b),
        .nBUSACK(nbusack_b), .bus_oe(oe_b), .in_tw(tw_b)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0; T1 = 1'b0; T2 = 1'b0; last_t = 1'b0;
        io_cycle = 1'b0; bus_cycle = 1'b1; nWAIT = 1'b0; nBUSRQ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (obs !== IDLE) begin bad++; $display("FAIL reset_a cyc%0d got=%b exp=%b", i, obs, IDLE); end
            total++;
            if (obs3 !== IDLE) begin bad++; $display("FAIL reset_b cyc%0d got=%b exp=%b", i, obs3, IDLE); end
        end
        next_cycle();
        nreset = 1'b1; nWAIT = 1'b1; nBUSRQ = 1'b1; T1 = 1'b1;
    endtask

    task automatic test_io_waits();
        logic [5:0] exp_a [4];
        logic [5:0] exp_b [4];
        exp_a = '{IORQ, IDLE, IDLE, IDLE};
        exp_b = '{IORQ, IORQ, IORQ, IDLE};
        next_cycle();
        T1 = 1'b0; T2 = 1'b1; io_cycle = 1'b1; bus_cycle = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) next_cycle();
            @(negedge clk);
            total++;
            if (obs !== exp_a[i]) begin bad++; $display("FAIL io_w1 cyc%0d got=%b exp=%b", i, obs, exp_a[i]); end
            total++;
            if (obs3 !== exp_b[i]) begin bad++; $display("FAIL io_w3 cyc%0d got=%b exp=%b", i, obs3, exp_b[i]); end
        end
        next_cycle();
        T2 = 1'b0; io_cycle = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== IDLE) begin bad++; $display("FAIL io_end got=%b exp=%b", obs, IDLE); end
    endtask

    task automatic test_ext_wait();
        next_cycle();
        T2 = 1'b1; io_cycle = 1'b0; bus_cycle = 1'b1; nWAIT = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) next_cycle();
            @(negedge clk);
            total++;
            if (obs !== WAIT) begin bad++; $display("FAIL mem_wait cyc%0d got=%b exp=%b", i, obs, WAIT); end
        end
        next_cycle();
        nWAIT = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== IDLE) begin bad++; $display("FAIL mem_wait_end got=%b exp=%b", obs, IDLE); end
        next_cycle();
        T2 = 1'b0;
        next_cycle();
        T2 = 1'b1; io_cycle = 1'b1; nWAIT = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== IORQ) begin bad++; $display("FAIL io_then_wait0 got=%b exp=%b", obs, IORQ); end
        next_cycle();
        @(negedge clk);
        total++;
        if (obs !== WAIT) begin bad++; $display("FAIL io_then_wait1 got=%b exp=%b", obs, WAIT); end
        next_cycle();
        nWAIT = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== IDLE) begin bad++; $display("FAIL io_then_wait2 got=%b exp=%b", obs, IDLE); end
        next_cycle();
        T2 = 1'b0; io_cycle = 1'b0;
    endtask

    task automatic test_bus_release();
        next_cycle();
        last_t = 1'b1; nBUSRQ = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== IDLE) begin bad++; $display("FAIL rel_req got=%b exp=%b", obs, IDLE); end
        next_cycle();
        last_t = 1'b0; T1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) next_cycle();
            @(negedge clk);
            total++;
            if (obs !== REL) begin bad++; $display("FAIL rel_hold cyc%0d got=%b exp=%b", i, obs, REL); end
        end
        next_cycle();
        nBUSRQ = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== REL) begin bad++; $display("FAIL rel_last got=%b exp=%b", obs, REL); end
        next_cycle();
        @(negedge clk);
        total++;
        if (obs !== RECV) begin bad++; $display("FAIL recover got=%b exp=%b", obs, RECV); end
        next_cycle();
        @(negedge clk);
        total++;
        if (obs !== IDLE) begin bad++; $display("FAIL rel_resume got=%b exp=%b", obs, IDLE); end
        T1 = 1'b0;
    endtask

    task automatic test_busrq_deferred();
        // Request raised during an I/O T2: ignored until last_t.
        next_cycle();
        T2 = 1'b1; io_cycle = 1'b1; bus_cycle = 1'b1; nBUSRQ = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== IORQ) begin bad++; $display("FAIL defer_t2a got=%b exp=%b", obs, IORQ); end
        next_cycle();
        @(negedge clk);
        total++;
        if (obs !== IDLE) begin bad++; $display("FAIL defer_t2b got=%b exp=%b", obs, IDLE); end
        next_cycle();
        T2 = 1'b0; io_cycle = 1'b0; last_t = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== IDLE) begin bad++; $display("FAIL defer_t3 got=%b exp=%b", obs, IDLE); end
        next_cycle();
        last_t = 1'b0; T1 = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== REL) begin bad++; $display("FAIL defer_rel got=%b exp=%b", obs, REL); end
        next_cycle();
        nBUSRQ = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== REL) begin bad++; $display("FAIL defer_rel2 got=%b exp=%b", obs, REL); end
        next_cycle();
        @(negedge clk);
        total++;
        if (obs !== RECV) begin bad++; $display("FAIL defer_recover got=%b exp=%b", obs, RECV); end
        next_cycle();
        @(negedge clk);
        total++;
        if (obs !== IDLE) begin bad++; $display("FAIL defer_run got=%b exp=%b", obs, IDLE); end

        // T2 and last_t together with an I/O hold: hold wins, request not taken.
        next_cycle();
        T1 = 1'b0; T2 = 1'b1; io_cycle = 1'b1; last_t = 1'b1; nBUSRQ = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== IORQ) begin bad++; $display("FAIL simul_hold got=%b exp=%b", obs, IORQ); end
        next_cycle();
        T2 = 1'b0; io_cycle = 1'b0; last_t = 1'b0; nBUSRQ = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== IDLE) begin bad++; $display("FAIL simul_norel got=%b exp=%b", obs, IDLE); end

        // One-clock pulse in T1 that ends before last_t is lost.
        next_cycle();
        T1 = 1'b1; nBUSRQ = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== IDLE) begin bad++; $display("FAIL pulse_t1 got=%b exp=%b", obs, IDLE); end
        next_cycle();
        T1 = 1'b0; T2 = 1'b1; nBUSRQ = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== IDLE) begin bad++; $display("FAIL pulse_t2 got=%b exp=%b", obs, IDLE); end
        next_cycle();
        T2 = 1'b0; last_t = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== IDLE) begin bad++; $display("FAIL pulse_t3 got=%b exp=%b", obs, IDLE); end
        next_cycle();
        last_t = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== IDLE) begin bad++; $display("FAIL pulse_never got=%b exp=%b", obs, IDLE); end
    endtask

    task automatic test_reset_in_rel();
        next_cycle();
        last_t = 1'b1; nBUSRQ = 1'b0;
        next_cycle();
        last_t = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== REL) begin bad++; $display("FAIL rst_rel_pre got=%b exp=%b", obs, REL); end
        #1;
        nreset = 1'b0;
        #1;
        total++;
        if (obs !== IDLE) begin bad++; $display("FAIL rst_rel_async got=%b exp=%b", obs, IDLE); end
        next_cycle();
        nBUSRQ = 1'b1;
        next_cycle();
        nreset = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== IDLE) begin bad++; $display("FAIL rst_rel_after got=%b exp=%b", obs, IDLE); end
    endtask

    task automatic test_sync_latency();
        logic [5:0] exp_a [4];
        logic [5:0] exp_b [4];
        exp_a = '{IDLE, REL, REL, REL};
        exp_b = '{IDLE, IDLE, IDLE, REL};
        next_cycle();
        nreset = 1'b0; T1 = 1'b0; T2 = 1'b0; last_t = 1'b0;
        io_cycle = 1'b0; nWAIT = 1'b1; nBUSRQ = 1'b1;
        next_cycle();
        nreset = 1'b1;
        next_cycle();
        nBUSRQ = 1'b0; last_t = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) next_cycle();
            @(negedge clk);
            total++;
            if (obs !== exp_a[i]) begin bad++; $display("FAIL sync0_rel cyc%0d got=%b exp=%b", i, obs, exp_a[i]); end
            total++;
            if (obs3 !== exp_b[i]) begin bad++; $display("FAIL sync1_rel cyc%0d got=%b exp=%b", i, obs3, exp_b[i]); end
        end
        next_cycle();
        nBUSRQ = 1'b1; last_t = 1'b0;
        repeat (5) next_cycle();
    endtask

    initial begin
        $display("[TB] bus_hold_ctl bench start");
        test_reset();
        test_io_waits();
        test_ext_wait();
        test_bus_release();
        test_busrq_deferred();
        test_reset_in_rel();
        test_sync_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
